// File: rtl/fighter_controller.sv
// fighter_controller: per-tick movement, jump physics, attack FSM and
// left-down-right combo detection for one fighter sprite.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   tick                one-clk game-rate enable; all state advances on it
//   btn_left/right/up/down/attack   debounced button levels
//   hit                 struck this tick (level, sampled on tick)
//   x, y                sprite anchor position
//   in_air              airborne flag
//   move_state          00 idle, 01 forward, 10 backward
//   character_state     000 NORMAL, 001 PUNCH, 010 SPECIAL, 100 INJURED
//   mirror              static facing (1 = facing left)
//   special_fired       one-clk pulse after a NORMAL->SPECIAL tick
module fighter_controller #(
  parameter int X_INIT       = 24,
  parameter int Y_GROUND     = 32,
  parameter int X_MIN        = 8,
  parameter int X_MAX        = 88,
  parameter int JUMP_V0      = 6,
  parameter int GRAVITY      = 1,
  parameter int PUNCH_TICKS  = 4,
  parameter int SP_TICKS     = 6,
  parameter int INJ_TICKS    = 5,
  parameter int COMBO_WINDOW = 8,
  parameter bit MIRROR_INIT  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_attack,
  input  logic       hit,
  output logic [6:0] x,
  output logic [6:0] y,
  output logic       in_air,
  output logic [1:0] move_state,
  output logic [2:0] character_state,
  output logic       mirror,
  output logic       special_fired
);

  typedef enum logic [2:0] {
    S_NORMAL  = 3'b000,
    S_PUNCH   = 3'b001,
    S_SPECIAL = 3'b010,
    S_INJURED = 3'b100
  } act_t;

  typedef enum logic [1:0] {C_IDLE, C_L, C_LD, C_LDR} combo_t;

  localparam logic [6:0]        XINIT_L = 7'(X_INIT);
  localparam logic [6:0]        XMIN_L  = 7'(X_MIN);
  localparam logic [6:0]        XMAX_L  = 7'(X_MAX);
  localparam logic [6:0]        YG_L    = 7'(Y_GROUND);
  localparam logic signed [8:0] YG9_L   = 9'(Y_GROUND);
  localparam logic signed [5:0] V0_L    = 6'(JUMP_V0);
  localparam logic signed [5:0] GRAV_L  = 6'(GRAVITY);
  localparam logic [7:0]        PUNCH_L = 8'(PUNCH_TICKS);
  localparam logic [7:0]        SP_L    = 8'(SP_TICKS);
  localparam logic [7:0]        INJ_L   = 8'(INJ_TICKS);
  localparam logic [7:0]        WIN_L   = 8'(COMBO_WINDOW);

  act_t               act_q, act_d;
  combo_t             combo_q, combo_d;
  logic [7:0]         act_cnt_q, act_cnt_d;
  logic [7:0]         win_cnt_q, win_cnt_d;
  logic [6:0]         x_q, x_d, y_q, y_d;
  logic signed [5:0]  vy_q, vy_d;
  logic               in_air_q, in_air_d;
  logic [1:0]         move_q, move_d;
  logic [4:0]         prev_q;
  logic               fired_q, fire_d;

  logic [4:0]         btn_now, press;
  logic signed [8:0]  ny, vy_ext;

  // bit order: {attack, down, up, right, left}
  assign btn_now = {btn_attack, btn_down, btn_up, btn_right, btn_left};
  assign press   = btn_now & ~prev_q;
  assign vy_ext  = {{3{vy_q[5]}}, vy_q};

  always_comb begin
    act_d     = act_q;
    act_cnt_d = act_cnt_q;
    combo_d   = combo_q;
    win_cnt_d = win_cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    vy_d      = vy_q;
    in_air_d  = in_air_q;
    move_d    = 2'b00;
    fire_d    = 1'b0;
    ny        = '0;

    // action FSM
    case (act_q)
      S_NORMAL: begin
        if (press[4]) begin
          if (combo_q == C_LDR) begin
            act_d     = S_SPECIAL;
            act_cnt_d = SP_L;
            fire_d    = 1'b1;
          end else begin
            act_d     = S_PUNCH;
            act_cnt_d = PUNCH_L;
          end
        end
      end
      S_PUNCH, S_SPECIAL, S_INJURED: begin
        if (act_cnt_q <= 8'd1) begin
          act_d     = S_NORMAL;
          act_cnt_d = '0;
        end else begin
          act_cnt_d = act_cnt_q - 8'd1;
        end
      end
      default: act_d = S_NORMAL;
    endcase
    if (hit) begin
      act_d     = S_INJURED;
      act_cnt_d = INJ_L;
      fire_d    = 1'b0;
    end

    // combo tracker; any attack press (which covers SPECIAL entry) clears it
    if (hit || press[4]) begin
      combo_d   = C_IDLE;
      win_cnt_d = '0;
    end else if (|press[3:0]) begin
      // only a lone expected press advances; a stray left press restarts at C_L
      if (combo_q == C_L && press[3:0] == 4'b1000) begin
        combo_d   = C_LD;
        win_cnt_d = WIN_L;
      end else if (combo_q == C_LD && press[3:0] == 4'b0010) begin
        combo_d   = C_LDR;
        win_cnt_d = WIN_L;
      end else if (press[0]) begin
        combo_d   = C_L;
        win_cnt_d = WIN_L;
      end else begin
        combo_d   = C_IDLE;
        win_cnt_d = '0;
      end
    end else if (combo_q != C_IDLE) begin
      if (win_cnt_q <= 8'd1) begin
        combo_d   = C_IDLE;
        win_cnt_d = '0;
      end else begin
        win_cnt_d = win_cnt_q - 8'd1;
      end
    end

    // walking
    if (act_q == S_NORMAL && (btn_left ^ btn_right)) begin
      if (btn_right) x_d = (x_q >= XMAX_L) ? XMAX_L : x_q + 7'd1;
      else           x_d = (x_q <= XMIN_L) ? XMIN_L : x_q - 7'd1;
      move_d = (btn_right ^ MIRROR_INIT) ? 2'b01 : 2'b10;
    end
    if (act_d != S_NORMAL) move_d = 2'b00;

    // vertical motion: airborne physics run regardless of action state
    if (in_air_q) begin
      ny   = $signed({2'b00, y_q}) - vy_ext;
      vy_d = vy_q - GRAV_L;
      if (ny[8]) begin
        y_d = '0;
      end else if (ny >= YG9_L) begin
        y_d      = YG_L;
        in_air_d = 1'b0;
        vy_d     = '0;
      end else begin
        y_d = ny[6:0];
      end
    end else if (act_q == S_NORMAL && btn_up) begin
      in_air_d = 1'b1;
      vy_d     = V0_L;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q     <= S_NORMAL;
      combo_q   <= C_IDLE;
      act_cnt_q <= '0;
      win_cnt_q <= '0;
      x_q       <= XINIT_L;
      y_q       <= YG_L;
      vy_q      <= '0;
      in_air_q  <= 1'b0;
      move_q    <= 2'b00;
      prev_q    <= '0;
      fired_q   <= 1'b0;
    end else begin
      fired_q <= 1'b0;
      if (tick) begin
        act_q     <= act_d;
        combo_q   <= combo_d;
        act_cnt_q <= act_cnt_d;
        win_cnt_q <= win_cnt_d;
        x_q       <= x_d;
        y_q       <= y_d;
        vy_q      <= vy_d;
        in_air_q  <= in_air_d;
        move_q    <= move_d;
        prev_q    <= btn_now;
        fired_q   <= fire_d;
      end
    end
  end

  assign x               = x_q;
  assign y               = y_q;
  assign in_air          = in_air_q;
  assign move_state      = move_q;
  assign character_state = act_q;
  assign mirror          = MIRROR_INIT;
  assign special_fired   = fired_q;

endmodule

// File: tb/tb_fighter_controller.sv
// Directed testbench for fighter_controller (default parameters).
module tb_fighter_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [4:0] btns;   // {attack, down, up, right, left}
  logic       hit;
  logic [6:0] x, y;
  logic       in_air;
  logic [1:0] move_state;
  logic [2:0] character_state;
  logic       mirror;
  logic       special_fired;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [4:0] B_L = 5'b00001;
  localparam logic [4:0] B_R = 5'b00010;
  localparam logic [4:0] B_U = 5'b00100;
  localparam logic [4:0] B_D = 5'b01000;
  localparam logic [4:0] B_A = 5'b10000;

  fighter_controller #(
    .X_INIT(24), .Y_GROUND(32), .X_MIN(8), .X_MAX(88), .JUMP_V0(6), .GRAVITY(1),
    .PUNCH_TICKS(4), .SP_TICKS(6), .INJ_TICKS(5), .COMBO_WINDOW(8), .MIRROR_INIT(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .btn_left(btns[0]), .btn_right(btns[1]), .btn_up(btns[2]),
    .btn_down(btns[3]), .btn_attack(btns[4]), .hit(hit),
    .x(x), .y(y), .in_air(in_air), .move_state(move_state),
    .character_state(character_state), .mirror(mirror),
    .special_fired(special_fired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one tick, followed by a sample point at the next falling edge
  task automatic step();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic tap(input logic [4:0] b);
    btns = b;
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_ticks(input int n);
    btns = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int yexp[13];
    yexp = '{26, 21, 17, 14, 12, 11, 11, 12, 14, 17, 21, 26, 32};
    rst_n = 1'b0;
    tick  = 1'b0;
    btns  = '0;
    hit   = 1'b0;
    do_reset();

    // reset state
    check("rst_x", x, 24);
    check("rst_y", y, 32);
    check("rst_in_air", in_air, 0);
    check("rst_move", move_state, 0);
    check("rst_state", character_state, 0);
    check("rst_fired", special_fired, 0);
    check("mirror", mirror, 0);

    // no advance without tick
    btns = B_R;
    repeat (4) @(negedge clk);
    check("no_tick_x", x, 24);

    // walk right to clamp
    for (int i = 1; i <= 70; i++) begin
      step();
      check("walk_r_x", x, (24 + i > 88) ? 88 : 24 + i);
      check("walk_r_move", move_state, 2'b01);
    end
    tap(B_L | B_R);
    check("both_x", x, 88);
    check("both_move", move_state, 0);
    btns = B_L;
    for (int i = 1; i <= 85; i++) begin
      step();
      check("walk_l_x", x, (88 - i < 8) ? 8 : 88 - i);
      check("walk_l_move", move_state, 2'b10);
    end
    idle_ticks(1);
    check("idle_move", move_state, 0);

    // jump arc
    btns = '0;
    do_reset();
    tap(B_U);
    check("jump_start_y", y, 32);
    check("jump_start_air", in_air, 1);
    btns = '0;
    for (int i = 0; i < 13; i++) begin
      step();
      check("arc_y", y, yexp[i]);
      check("arc_air", in_air, (i < 12) ? 1 : 0);
    end

    // punch: 4 ticks, re-press ignored, no walking while punching
    do_reset();
    tap(B_A);
    check("punch_0", character_state, 3'b001);
    tap(B_R);
    check("punch_1", character_state, 3'b001);
    check("punch_move", move_state, 0);
    tap(B_R | B_A);
    check("punch_2", character_state, 3'b001);
    tap(B_R);
    check("punch_3", character_state, 3'b001);
    tap('0);
    check("punch_end", character_state, 3'b000);
    check("punch_x", x, 24);

    // combo -> special
    do_reset();
    tap(B_L); tap(B_D); tap(B_R); tap(B_A);
    check("sp_state", character_state, 3'b010);
    check("sp_fired", special_fired, 1);
    @(negedge clk);
    check("sp_fired_off", special_fired, 0);
    btns = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("sp_hold", character_state, 3'b010);
      check("sp_no_refire", special_fired, 0);
    end
    step();
    check("sp_end", character_state, 3'b000);

    // combo expired by 9-tick gap -> punch
    tap(B_L); tap(B_D); tap(B_R);
    idle_ticks(9);
    tap(B_A);
    check("gap_punch", character_state, 3'b001);
    check("gap_fired", special_fired, 0);
    idle_ticks(5);

    // stray left restarts the sequence
    tap(B_L); tap(B_D); tap(B_L); tap(B_D); tap(B_R); tap(B_A);
    check("restart_sp", character_state, 3'b010);
    idle_ticks(7);
    check("restart_end", character_state, 3'b000);

    // out-of-sequence press breaks the combo
    tap(B_L); tap(B_D); tap(B_U); tap(B_R); tap(B_A);
    check("oos_punch", character_state, 3'b001);
    idle_ticks(5);

    // hit beats attack on the same tick
    do_reset();
    btns = B_A;
    hit  = 1'b1;
    step();
    check("prio_inj", character_state, 3'b100);
    hit = 1'b0;
    btns = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("inj_hold", character_state, 3'b100);
    end
    step();
    check("inj_end", character_state, 3'b000);

    // hit during special aborts it
    tap(B_L); tap(B_D); tap(B_R); tap(B_A);
    check("sp2_state", character_state, 3'b010);
    tap('0);
    hit = 1'b1;
    step();
    hit = 1'b0;
    check("sp_abort", character_state, 3'b100);
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort_hold", character_state, 3'b100);
    end
    step();
    check("abort_end", character_state, 3'b000);

    // hit while injured reloads the counter
    hit = 1'b1; step();
    hit = 1'b0; step();
    hit = 1'b1; step();
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("reload_hold", character_state, 3'b100);
    end
    step();
    check("reload_end", character_state, 3'b000);

    // reset during airborne punch
    do_reset();
    tap(B_U);
    tap('0);
    tap('0);
    tap(B_A);
    check("air_punch_state", character_state, 3'b001);
    check("air_punch_y", y, 17);
    check("air_punch_air", in_air, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_x", x, 24);
    check("async_y", y, 32);
    check("async_state", character_state, 0);
    check("async_air", in_air, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();  // attack still held: counts as a press after reset
    check("post_rst_punch", character_state, 3'b001);
    check("post_rst_y", y, 32);
    check("post_rst_air", in_air, 0);
    idle_ticks(2);
    check("post_rst_y2", y, 32);
    check("post_rst_x", x, 24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fighter_controller.md
FIGHTER_CONTROLLER -- requirements
Module: fighter_controller

Interface
REQ-001 The parameters SHALL be: X_INIT, default 24, reset x position.
REQ-002 The parameters SHALL be: Y_GROUND, default 32, standing y position.
REQ-003 The parameters SHALL be: X_MIN / X_MAX, defaults 8 / 88, horizontal clamp bounds.
REQ-004 The parameters SHALL be: JUMP_V0, default 6, initial upward speed; GRAVITY, default 1, per-tick speed decrement.
REQ-005 The parameters SHALL be: PUNCH_TICKS 4, SP_TICKS 6, INJ_TICKS 5, COMBO_WINDOW 8 (all in ticks); MIRROR_INIT 0, facing (1 = facing left).
REQ-006 The design SHALL use one clock and an asynchronous, active-low reset: clk input 1 system clock; rst_n input 1 async active-low reset.
REQ-007 The design SHALL have port tick, input, 1 bit: one-clk game-rate enable pulse; all state updates occur only on clk edges where tick=1.
REQ-008 The design SHALL have ports btn_left, btn_right, btn_up, btn_down, btn_attack, input, 1 bit each: debounced button levels.
REQ-009 The design SHALL have port hit, input, 1 bit: level, sampled on tick, that means the fighter was struck.
REQ-010 The design SHALL have ports x and y, output, 7 bits each: sprite anchor position for the sprite renderer.
REQ-011 The design SHALL have port in_air, output, 1 bit: airborne flag.
REQ-012 The design SHALL have port move_state, output, 2 bits: 00 idle, 01 forward, 10 backward.
REQ-013 The design SHALL have port character_state, output, 3 bits: 000 NORMAL, 001 PUNCH, 010 SPECIAL, 100 INJURED.
REQ-014 The design SHALL have port mirror, output, 1 bit: equal to MIRROR_INIT (static facing).
REQ-015 The design SHALL have port special_fired, output, 1 bit: one-clk pulse on SPECIAL entry (projectile spawn).

Function
REQ-016 Buttons SHALL be sampled only on tick; a button "press" is sampled=1 where the previous tick's sample was 0.
REQ-017 Forward direction SHALL be +x when mirror=0 and -x when mirror=1.
REQ-018 Walking SHALL occur only in NORMAL: exactly one of left/right held -> x moves 1 per tick, move_state = 01/10 per REQ-017; both or neither held -> x unchanged, move_state 00.
REQ-019 x SHALL saturate at X_MIN and X_MAX; a blocked walk still reports the held move_state.
REQ-020 move_state SHALL be 00 in any state other than NORMAL.
REQ-021 Jump: btn_up held on a tick with in_air=0 and NORMAL -> in_air=1 and vy=JUMP_V0.
REQ-022 While airborne, each tick SHALL apply y <= y - vy, then vy <= vy - GRAVITY; vy is signed 6-bit.
REQ-023 y SHALL clamp at 0 on the top edge.
REQ-024 Landing: if the computed y >= Y_GROUND, then y <= Y_GROUND, in_air <= 0, vy <= 0 in the same tick.
REQ-025 Airborne physics SHALL continue in every character_state.
REQ-026 Action FSM: NORMAL + attack press -> SPECIAL if the combo tracker is in C_LDR, else PUNCH; the tick counter loads PUNCH_TICKS or SP_TICKS.
REQ-027 In PUNCH and SPECIAL, the counter SHALL decrement per tick and return to NORMAL on the tick it reaches 0; attack presses are ignored there.
REQ-028 hit=1 on a tick from any state SHALL enter INJURED with counter INJ_TICKS, aborting PUNCH/SPECIAL; hit while already INJURED reloads the counter.
REQ-029 INJURED SHALL exit to NORMAL on expiry.
REQ-030 hit and attack press on the same tick -> INJURED wins.
REQ-031 Combo tracker states SHALL be C_IDLE -> C_L (left press) -> C_LD (down press) -> C_LDR (right press).
REQ-032 Each combo advance SHALL reload the window counter to COMBO_WINDOW; the counter decrements per tick in non-idle states, and reaching 0 -> C_IDLE.
REQ-033 Any out-of-sequence direction press SHALL return the tracker to C_IDLE, except a left press, which goes to C_L.
REQ-034 The tracker SHALL return to C_IDLE on SPECIAL entry, on any attack press, and on INJURED entry.
REQ-035 special_fired SHALL be high exactly for the clk cycle following the NORMAL->SPECIAL tick.
REQ-036 Outputs SHALL be registered; a tick's effects are visible 1 clk after that tick.

Reset
REQ-037 rst_n=0 SHALL asynchronously set x=X_INIT, y=Y_GROUND, in_air=0, vy=0, move_state=00, character_state=000, special_fired=0, tracker C_IDLE, all counters 0, and button history 0.
REQ-038 Reset mid-jump or mid-attack SHALL fully abort, with no residual motion after release.
REQ-039 The first tick after release SHALL treat a held button as a press.

Verification
REQ-040 Walk clamp: right held 70 ticks from reset -> x rises 1 per tick to 88 and holds; move_state=01 throughout.
REQ-041 Jump arc: up held 1 tick (defaults) -> y sequence 26,21,17,14,12,11,11,12,14,17,21,26,32, then in_air=0.
REQ-042 Punch: attack press -> character_state=001 for 4 ticks, then 000; re-press during punch ignored.
REQ-043 Combo: presses left, down, right, attack on consecutive ticks -> character_state=010 for 6 ticks and a single special_fired pulse; the same sequence with a 9-tick gap -> PUNCH instead.
REQ-044 Priority: hit and attack press on the same tick -> 100 for 5 ticks; hit during SPECIAL aborts it to INJURED.
REQ-045 Reset during airborne PUNCH -> immediate x=24, y=32, state 000, in_air=0.
